// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
//
// Types and constants shared by the fetch/decode side of the dual-issue
// pipeline. The instruction FIFO stores one fifo_entry_t per fetched
// instruction.
//
// Contents:
//   fifo_entry_t     - {pc, inst} pair kept in each FIFO slot
//   INST_FIFO_DEPTH  - default number of FIFO entries
//   pair_count()     - turns a (slot1, slot2) enable pair into 0/1/2, where
//                      slot 2 only counts when slot 1 is also enabled
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int INST_FIFO_DEPTH = 16;

    // Slot 2 is meaningless without slot 1, so {1,1} -> 2, {1,0} -> 1,
    // and anything with en1 low -> 0.
    function automatic logic [1:0] pair_count(input logic en1, input logic en2);
        return {en1 & en2, en1 & ~en2};
    endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// ---------------------------------------------------------------------------
// inst_fifo_if
//
// Bundles the fetch-side push port, the decode-side pop port and the status
// flags of the instruction FIFO.
//
// Modports:
//   master - the pipeline side: drives write_*/read_en*, observes read data
//            and the empty/full flags
//   slave  - the FIFO itself
//
// Signals:
//   write_en1/2, write_inst1/2, write_pc1/2  push up to two instructions
//   read_en1/2                               consume up to two instructions
//   read_inst1/2, read_pc1/2                 head and head+1 entries
//   read_valid1/2                            head / head+1 entry present
//   fifo_empty, fifo_full                    status (full = two-wide push
//                                            might not fit)
// ---------------------------------------------------------------------------
interface inst_fifo_if;

    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_inst1;
    logic [31:0] write_inst2;
    logic [31:0] write_pc1;
    logic [31:0] write_pc2;

    logic        read_en1;
    logic        read_en2;
    logic [31:0] read_inst1;
    logic [31:0] read_inst2;
    logic [31:0] read_pc1;
    logic [31:0] read_pc2;
    logic        read_valid1;
    logic        read_valid2;

    logic        fifo_empty;
    logic        fifo_full;

    modport master (
        output write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        output read_en1, read_en2,
        input  read_inst1, read_inst2, read_pc1, read_pc2,
        input  read_valid1, read_valid2, fifo_empty, fifo_full
    );

    modport slave (
        input  write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        input  read_en1, read_en2,
        output read_inst1, read_inst2, read_pc1, read_pc2,
        output read_valid1, read_valid2, fifo_empty, fifo_full
    );

endinterface

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
//
// Two-in / two-out decoupling buffer between instruction fetch and decode.
// Up to two {pc, inst} pairs are pushed per cycle and up to two are offered
// to decode per cycle. fifo_full is the hold condition for PC generation:
// while it is high, fetch re-requests the same PC.
//
// Parameters:
//   DEPTH   number of entries, power of two, >= 4
//   ADDR_W  pointer width
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-low reset
//   flush   synchronous clear (redirect / mispredict / exception); wins over
//           any same-cycle push or pop
//   fifo    inst_fifo_if.slave bundle (push, pop, read data, status)
//
// Optional feature, enabled with `define INST_FIFO_PERF_EN:
//   perf_full_cycles   cycles spent with fifo_full = 1  (saturating)
//   perf_empty_cycles  cycles spent with fifo_empty = 1 (saturating)
//   Both clear on rst only; flush leaves them alone.
// ---------------------------------------------------------------------------
module inst_fifo
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH  = INST_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    inst_fifo_if.slave fifo
`ifdef INST_FIFO_PERF_EN
    ,
    output logic [31:0] perf_full_cycles,
    output logic [31:0] perf_empty_cycles
`endif
);

    // Storage is deliberately not reset; validity comes only from count.
    fifo_entry_t       mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic [ADDR_W-1:0] wr_ptr_p1;
    logic [ADDR_W-1:0] rd_ptr_p1;

    logic [ADDR_W:0]   nwr;
    logic [ADDR_W:0]   nrd_req;
    logic [ADDR_W:0]   nrd;
    logic [ADDR_W:0]   count_after_pop;
    logic [ADDR_W:0]   nwr_acc;
    logic              push_ok;
    logic              do_push;

    logic              is_empty;
    logic              is_full;

    assign wr_ptr_p1 = wr_ptr + ADDR_W'(1);
    assign rd_ptr_p1 = rd_ptr + ADDR_W'(1);

    // Requested push/pop widths; the second slot only counts with the first.
    assign nwr     = (ADDR_W+1)'(pair_count(fifo.write_en1, fifo.write_en2));
    assign nrd_req = (ADDR_W+1)'(pair_count(fifo.read_en1, fifo.read_en2));

    // Popping more than is stored would underflow; clip to what is there.
    assign nrd = (nrd_req > count) ? count : nrd_req;

    // A push is all-or-nothing: it is taken only if it fits after this
    // cycle's pops have freed their slots.
    assign count_after_pop = count - nrd;
    assign push_ok         = (count_after_pop + nwr) <= (ADDR_W+1)'(DEPTH);
    assign nwr_acc         = push_ok ? nwr : '0;
    assign do_push         = push_ok && !flush;

    // Pointer and occupancy update. Flush discards the whole cycle's traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(nwr_acc);
            rd_ptr <= rd_ptr + ADDR_W'(nrd);
            count  <= count_after_pop + nwr_acc;
        end
    end

    // Entry writes. Slot 2 lands at wr_ptr+1, which wraps naturally, so a
    // pair straddling the last index simply splits across the end.
    always_ff @(posedge clk) begin
        if (do_push && fifo.write_en1) begin
            mem[wr_ptr] <= '{pc: fifo.write_pc1, inst: fifo.write_inst1};
        end
        if (do_push && fifo.write_en1 && fifo.write_en2) begin
            mem[wr_ptr_p1] <= '{pc: fifo.write_pc2, inst: fifo.write_inst2};
        end
    end

    // Read side and flags depend on registered state only (no write bypass).
    assign is_empty = (count == '0);
    assign is_full  = (count >= (ADDR_W+1)'(DEPTH - 2));

    assign fifo.read_pc1    = mem[rd_ptr].pc;
    assign fifo.read_inst1  = mem[rd_ptr].inst;
    assign fifo.read_pc2    = mem[rd_ptr_p1].pc;
    assign fifo.read_inst2  = mem[rd_ptr_p1].inst;
    assign fifo.read_valid1 = !is_empty;
    assign fifo.read_valid2 = (count >= (ADDR_W+1)'(2));
    assign fifo.fifo_empty  = is_empty;
    assign fifo.fifo_full   = is_full;

`ifdef INST_FIFO_PERF_EN
    // Occupancy statistics; they saturate instead of wrapping so a long run
    // never reports a misleadingly small number.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (is_full && (perf_full_cycles != '1)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (is_empty && (perf_empty_cycles != '1)) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// ---------------------------------------------------------------------------
// tb_inst_fifo
//
// Self-checking bench for inst_fifo (DEPTH = 16). A queue of {pc, inst}
// records acts as the reference: pops take from the front, pushes append
// at the back, and the flags follow from the queue length. A fixed vector
// table, hand-written corner sequences and a randomized run are compared
// against it. Also builds with `define INST_FIFO_PERF_EN.
// ---------------------------------------------------------------------------
module tb_inst_fifo;
    import cpu_defs_pkg::*;

    localparam int DEPTH = INST_FIFO_DEPTH;

    logic clk;
    logic rst;
    logic flush;

    inst_fifo_if fif();

`ifdef INST_FIFO_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_empty_cycles;
    int          model_full_cycles;
    int          model_empty_cycles;
`endif

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fifo(fif)
`ifdef INST_FIFO_PERF_EN
        ,
        .perf_full_cycles(perf_full_cycles),
        .perf_empty_cycles(perf_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    fifo_entry_t model_q[$];
    bit          allow_drop = 1'b0;

    typedef struct {
        bit          fl;
        bit          we1;
        bit          we2;
        bit          re1;
        bit          re2;
        logic [31:0] pc1;
        logic [31:0] inst1;
        logic [31:0] pc2;
        logic [31:0] inst2;
        bit          v1;
        bit          v2;
        bit          empty;
        bit          full;
        logic [31:0] epc1;
        logic [31:0] einst1;
        logic [31:0] epc2;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input bit fl, input bit we1, input bit we2,
                                input bit re1, input bit re2,
                                input logic [31:0] pc1, input logic [31:0] inst1,
                                input logic [31:0] pc2, input logic [31:0] inst2,
                                input bit v1, input bit v2, input bit empty, input bit full,
                                input logic [31:0] epc1, input logic [31:0] einst1,
                                input logic [31:0] epc2);
        vec_t v;
        v.fl = fl; v.we1 = we1; v.we2 = we2; v.re1 = re1; v.re2 = re2;
        v.pc1 = pc1; v.inst1 = inst1; v.pc2 = pc2; v.inst2 = inst2;
        v.v1 = v1; v.v2 = v2; v.empty = empty; v.full = full;
        v.epc1 = epc1; v.einst1 = einst1; v.epc2 = epc2;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the reference queue.
    task automatic check_output(input string tag);
        int n;
        n = model_q.size();
        check_bit({tag, " valid1"}, fif.read_valid1, n >= 1);
        check_bit({tag, " valid2"}, fif.read_valid2, n >= 2);
        check_bit({tag, " empty"},  fif.fifo_empty,  n == 0);
        check_bit({tag, " full"},   fif.fifo_full,   n >= DEPTH - 2);
        if (n >= 1) begin
            check_word({tag, " pc1"},   fif.read_pc1,   model_q[0].pc);
            check_word({tag, " inst1"}, fif.read_inst1, model_q[0].inst);
        end
        if (n >= 2) begin
            check_word({tag, " pc2"},   fif.read_pc2,   model_q[1].pc);
            check_word({tag, " inst2"}, fif.read_inst2, model_q[1].inst);
        end
    endtask

    // Reference behaviour for one clock edge with reset released.
    task automatic model_step(input bit fl, input bit we1, input bit we2,
                              input bit re1, input bit re2,
                              input fifo_entry_t e1, input fifo_entry_t e2);
        int nrd;
        int nwr;
`ifdef INST_FIFO_PERF_EN
        if (model_q.size() >= DEPTH - 2) model_full_cycles++;
        if (model_q.size() == 0) model_empty_cycles++;
`endif
        if (fl) begin
            model_q.delete();
            return;
        end
        nrd = re1 ? (re2 ? 2 : 1) : 0;
        if (nrd > model_q.size()) nrd = model_q.size();
        nwr = we1 ? (we2 ? 2 : 1) : 0;
        repeat (nrd) void'(model_q.pop_front());
        if (model_q.size() + nwr <= DEPTH) begin
            if (nwr >= 1) model_q.push_back(e1);
            if (nwr == 2) model_q.push_back(e2);
        end else if (!allow_drop) begin
            errors++;
            $display("[TB] FAIL dropped push: occupancy %0d plus %0d", model_q.size(), nwr);
        end
    endtask

    task automatic apply_stimulus(input bit fl, input bit we1, input bit we2,
                                  input logic [31:0] pc1, input logic [31:0] inst1,
                                  input logic [31:0] pc2, input logic [31:0] inst2,
                                  input bit re1, input bit re2);
        flush           = fl;
        fif.write_en1   = we1;
        fif.write_en2   = we2;
        fif.write_pc1   = pc1;
        fif.write_inst1 = inst1;
        fif.write_pc2   = pc2;
        fif.write_inst2 = inst2;
        fif.read_en1    = re1;
        fif.read_en2    = re2;
        @(posedge clk);
        model_step(fl, we1, we2, re1, re2, '{pc: pc1, inst: inst1}, '{pc: pc2, inst: inst2});
        #1;
        flush         = 1'b0;
        fif.write_en1 = 1'b0;
        fif.write_en2 = 1'b0;
        fif.read_en1  = 1'b0;
        fif.read_en2  = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        flush         = 1'b0;
        fif.write_en1 = 1'b0;
        fif.write_en2 = 1'b0;
        fif.read_en1  = 1'b0;
        fif.read_en2  = 1'b0;
        model_q.delete();
`ifdef INST_FIFO_PERF_EN
        model_full_cycles  = 0;
        model_empty_cycles = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit          r_fl, r_we1, r_we2, r_re1, r_re2;
        logic [31:0] r_pc1, r_pc2, r_i1, r_i2;

        fif.write_pc1   = '0;
        fif.write_pc2   = '0;
        fif.write_inst1 = '0;
        fif.write_inst2 = '0;

        // ------------------------------------------------------------------
        // Vector table: one row per cycle starting from reset.
        //            fl we1 we2 re1 re2  pc1          inst1        pc2          inst2         v1 v2 em fu  epc1         einst1       epc2
        vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 32'hBFC00000, 32'h24080001, 32'hBFC00004, 32'h24090002, 1, 1, 0, 0, 32'hBFC00000, 32'h24080001, 32'hBFC00004);
        vecs[2]  = mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 32'h0DEAD000, 32'h0,        32'h0DEAD004, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 32'h00000200, 32'h11110200, 32'h0,        32'h0,        1, 0, 0, 0, 32'h00000200, 32'h11110200, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h00000200, 32'h11110200, 32'h0);
        vecs[6]  = mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 32'h00000300, 32'h33330300, 32'h00000304, 32'h33330304, 1, 1, 0, 0, 32'h00000300, 32'h33330300, 32'h00000304);
        vecs[9]  = mk(0, 1, 1, 1, 0, 32'h00000308, 32'h33330308, 32'h0000030C, 32'h3333030C, 1, 1, 0, 0, 32'h00000304, 32'h33330304, 32'h00000308);
        vecs[10] = mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h0000030C, 32'h3333030C, 32'h0);
        vecs[11] = mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h0);

        // Reset then idle.
        do_reset();
        check_bit("reset empty",  fif.fifo_empty,  1'b1);
        check_bit("reset full",   fif.fifo_full,   1'b0);
        check_bit("reset valid1", fif.read_valid1, 1'b0);
        check_bit("reset valid2", fif.read_valid2, 1'b0);

        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply_stimulus(vecs[i].fl, vecs[i].we1, vecs[i].we2,
                           vecs[i].pc1, vecs[i].inst1, vecs[i].pc2, vecs[i].inst2,
                           vecs[i].re1, vecs[i].re2);
            check_bit({tag, " valid1"}, fif.read_valid1, vecs[i].v1);
            check_bit({tag, " valid2"}, fif.read_valid2, vecs[i].v2);
            check_bit({tag, " empty"},  fif.fifo_empty,  vecs[i].empty);
            check_bit({tag, " full"},   fif.fifo_full,   vecs[i].full);
            if (vecs[i].v1) begin
                check_word({tag, " pc1"},   fif.read_pc1,   vecs[i].epc1);
                check_word({tag, " inst1"}, fif.read_inst1, vecs[i].einst1);
            end
            if (vecs[i].v2) check_word({tag, " pc2"}, fif.read_pc2, vecs[i].epc2);
        end

        // ------------------------------------------------------------------
        // Fill to full, one more pair fits, a pair at 15 is dropped whole.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(0, 1, 1, 32'h1000 + 32'(8*k), 32'hF000 + 32'(k),
                           32'h1004 + 32'(8*k), 32'hF100 + 32'(k), 0, 0);
            check_output($sformatf("fill%0d", k));
            if (k == 5) check_bit("fill count12 full", fif.fifo_full, 1'b0);
        end
        check_bit("fill count14 full", fif.fifo_full, 1'b1);
        apply_stimulus(0, 1, 1, 32'h1038, 32'hF007, 32'h103C, 32'hF107, 0, 0);
        check_bit("fill count16 full", fif.fifo_full, 1'b1);
        check_bit("fill count16 valid2", fif.read_valid2, 1'b1);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        allow_drop = 1'b1;
        apply_stimulus(0, 1, 1, 32'h9000, 32'hDEAD0000, 32'h9004, 32'hDEAD0004, 0, 0);
        allow_drop = 1'b0;
        check_output("drop");
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
            check_output($sformatf("drain%0d", k));
        end
        check_bit("drain last valid1", fif.read_valid1, 1'b1);
        check_bit("drain last valid2", fif.read_valid2, 1'b0);
        check_word("drain last pc1", fif.read_pc1, 32'h103C);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check_bit("drain done empty", fif.fifo_empty, 1'b1);

        // ------------------------------------------------------------------
        // Wrap-around: walk both pointers to index 15, then push a pair.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            apply_stimulus(0, 1, 0, 32'h4000 + 32'(4*k), 32'(k), 32'h0, 32'h0, 1, 0);
        end
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check_output("wrap pre");
        apply_stimulus(0, 1, 1, 32'h100, 32'hAAAA0100, 32'h104, 32'hAAAA0104, 0, 0);
        check_word("wrap pc1", fif.read_pc1, 32'h100);
        check_word("wrap pc2", fif.read_pc2, 32'h104);
        check_word("wrap inst2", fif.read_inst2, 32'hAAAA0104);
        check_bit("wrap valid2", fif.read_valid2, 1'b1);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
        check_bit("wrap popped empty", fif.fifo_empty, 1'b1);

        // ------------------------------------------------------------------
        // Flush with concurrent push and pop at count 5.
        do_reset();
        apply_stimulus(0, 1, 1, 32'h500, 32'h5000, 32'h504, 32'h5004, 0, 0);
        apply_stimulus(0, 1, 1, 32'h508, 32'h5008, 32'h50C, 32'h500C, 0, 0);
        apply_stimulus(0, 1, 0, 32'h510, 32'h5010, 32'h0, 32'h0, 0, 0);
        check_output("preflush");
        apply_stimulus(1, 1, 1, 32'h5A0, 32'h50A0, 32'h5A4, 32'h50A4, 1, 0);
        check_bit("flush empty",  fif.fifo_empty,  1'b1);
        check_bit("flush valid1", fif.read_valid1, 1'b0);
        check_bit("flush full",   fif.fifo_full,   1'b0);
        check_bit("push cycle valid1", fif.read_valid1, 1'b0);
        apply_stimulus(0, 1, 0, 32'h5C0, 32'h55550000, 32'h0, 32'h0, 0, 0);
        check_bit("postflush valid1", fif.read_valid1, 1'b1);
        check_word("postflush pc1", fif.read_pc1, 32'h5C0);
        check_word("postflush inst1", fif.read_inst1, 32'h55550000);

        // ------------------------------------------------------------------
        // Async reset in the middle of a cycle at count 6.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(0, 1, 1, 32'h600 + 32'(8*k), 32'h6000 + 32'(k),
                           32'h604 + 32'(8*k), 32'h6100 + 32'(k), 0, 0);
        end
        check_output("prereset");
        #3;
        rst           = 1'b0;
        flush         = 1'b1;
        fif.write_en1 = 1'b1;
        #1;
        check_bit("async empty",  fif.fifo_empty,  1'b1);
        check_bit("async full",   fif.fifo_full,   1'b0);
        check_bit("async valid1", fif.read_valid1, 1'b0);
        check_bit("async valid2", fif.read_valid2, 1'b0);
        do_reset();
        check_output("after async");

        // ------------------------------------------------------------------
        // Randomized traffic; upstream honours fifo_full.
        for (int i = 0; i < 800; i++) begin
            r_fl  = ($urandom_range(0, 39) == 0);
            r_we1 = ($urandom_range(0, 3) != 0) && (model_q.size() < DEPTH - 2);
            r_we2 = ($urandom_range(0, 1) == 1);
            r_re1 = ($urandom_range(0, 2) != 0);
            r_re2 = ($urandom_range(0, 1) == 1);
            r_pc1 = $urandom & 32'hFFFF_FFFC;
            r_pc2 = r_pc1 + 32'd4;
            r_i1  = $urandom;
            r_i2  = $urandom;
            apply_stimulus(r_fl, r_we1, r_we2, r_pc1, r_i1, r_pc2, r_i2, r_re1, r_re2);
            check_output($sformatf("rand%0d", i));
        end

`ifdef INST_FIFO_PERF_EN
        check_word("perf full cycles",  perf_full_cycles,  32'(model_full_cycles));
        check_word("perf empty cycles", perf_empty_cycles, 32'(model_empty_cycles));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Decoupling buffer between instruction fetch and decode in the dual-issue pipeline.
- Accepts up to two fetched instructions (with their PCs) per cycle and presents up to two to decode per cycle.
- Its fifo_full output is the D_fifo_full hold condition consumed by PC generation; when it is asserted, fetch re-requests the same PC.
- Flushed on branch/jump redirect, mispredict and exception.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries.
- write_en1  in  1  push slot 1.
- write_en2  in  1  push slot 2; honoured only together with write_en1.
- write_inst1  in  32  instruction, slot 1.
- write_inst2  in  32  instruction, slot 2.
- write_pc1  in  32  PC, slot 1.
- write_pc2  in  32  PC, slot 2.
- read_en1  in  1  decode consumes head entry.
- read_en2  in  1  decode consumes second entry; honoured only together with read_en1.
- read_inst1  out  32  head instruction.
- read_inst2  out  32  head+1 instruction.
- read_pc1  out  32  head PC.
- read_pc2  out  32  head+1 PC.
- read_valid1  out  1  count >= 1.
- read_valid2  out  1  count >= 2.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count >= DEPTH-2, i.e. a two-wide push might not fit.

Behaviour:
- State: entry array of {pc, inst}, wr_ptr, rd_ptr (ADDR_W bits), count (ADDR_W+1 bits). Entries are not reset.
- Reset (rst low, async): wr_ptr = rd_ptr = 0, count = 0, so fifo_empty = 1, fifo_full = 0, read_valid1/2 = 0. Read data outputs are don't-care while invalid.
- Outputs are combinational from registered state only:
  - read_inst1/read_pc1 come from entry[rd_ptr].
  - read_inst2/read_pc2 come from entry[rd_ptr+1 mod DEPTH].
- Effective counts:
  - nwr = write_en1 + (write_en1 & write_en2).
  - nrd = read_en1 + (read_en1 & read_en2), clipped to count. read_en with an invalid slot is ignored and causes no underflow.
- Overflow guard: a push is accepted only if count - nrd + nwr <= DEPTH; otherwise the entire push is dropped (no partial write). Upstream is required to respect fifo_full, so the bench flags a dropped push as an error.
- Write: slot 1 goes to entry[wr_ptr], slot 2 to entry[wr_ptr+1]. wr_ptr advances by nwr, mod DEPTH.
- Read: rd_ptr advances by nrd, mod DEPTH. count_next = count + nwr - nrd.
- Latency: a written entry is visible on the read outputs the cycle after the write, with no bypass. Pushing into an empty FIFO therefore yields read_valid1 = 0 in that cycle.
- Simultaneous push and pop at any count (including full-minus-two and one entry) is legal and handled by the arithmetic above.
- Wrap-around: pointer arithmetic wraps naturally at DEPTH. A two-wide push/pop straddling the index DEPTH-1 to 0 is legal.
- Flush: highest priority. On the next edge pointers and count go to 0; same-cycle pushes and pops are discarded. Writes in the cycle after flush are accepted normally.
- Async reset mid-operation: everything returns to reset values immediately, regardless of flush or enables.

Optional Feature:
- Macro INST_FIFO_PERF_EN.
- Defined:
  - Adds outputs perf_full_cycles [31:0] and perf_empty_cycles [31:0].
  - Each counts cycles with fifo_full = 1 or fifo_empty = 1 respectively, saturating at 32'hFFFFFFFF.
  - Reset to 0 by rst; not cleared by flush.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defs_pkg:
  - typedef fifo_entry_t {logic [31:0] pc; logic [31:0] inst;}.
  - localparam INST_FIFO_DEPTH = 16.
- No sub-module is required. The optional perf counter pair may be a sub-module sat_counter (WIDTH = 32, inc, clear).

Test Plan:
1. Reset then idle: rst low for 2 cycles, then high -> fifo_empty = 1, fifo_full = 0, read_valid1/2 = 0, all held with no enables.
2. Dual push, dual pop: push {pc 0xBFC00000, inst 0x24080001} and {0xBFC00004, 0x24090002}.
   - Next cycle: read_pc1 = 0xBFC00000, read_pc2 = 0xBFC00004, read_valid1/2 = 1.
   - After read_en1 = read_en2 = 1: fifo_empty = 1.
3. Fill to full: 7 dual pushes with no pops -> count 14, fifo_full = 1.
   - One further dual push fits (count 16).
   - A dual push at count 15 is dropped whole.
4. Wrap-around: DEPTH = 16 with rd_ptr = wr_ptr = 15; push PCs 0x100 and 0x104 -> entries land at indices 15 and 0; next cycle read_pc1 = 0x100, read_pc2 = 0x104.
5. Flush with concurrent traffic: count 5 with flush, a dual push and read_en1 all in one cycle -> next cycle count 0, fifo_empty = 1; a push the following cycle is visible one cycle later.
6. Single-entry dual pop and async reset: count 1 with read_en1 = read_en2 = 1 -> count 0, no underflow. Then rst low mid-cycle at count 6 -> outputs return to reset values before the next edge.
